// File: rtl/sfifo_rr_arbiter_pkg.sv
// Shared definitions for the round-robin source arbiters: producer index type for the
// default four-producer build and the burst-counter width helper.
package sfifo_rr_arbiter_pkg;

    localparam int unsigned DefNsrc = 4;

    typedef logic [$clog2(DefNsrc)-1:0] id_t;

    // Enough bits to count 0..burst; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned burst);
        return (burst < 1) ? 1 : $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/sfifo_rr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: returns the first set request bit found when
// scanning from i_start upwards, modulo NSRC.
module sfifo_rr_arbiter_rr_pick #(
    parameter int unsigned NSRC = 4,
    localparam int unsigned CL_S = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] i_req,
    input  logic [CL_S-1:0] i_start,
    output logic            o_any,
    output logic [CL_S-1:0] o_idx
);

    localparam logic [CL_S:0] NsrcW = (CL_S + 1)'(NSRC);

    logic            found;
    logic [CL_S:0]   sum;
    logic [CL_S-1:0] cand;

    always_comb begin
        o_any = |i_req;
        o_idx = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NSRC; k++) begin
            // One extra bit so the wrap works for non-power-of-two NSRC.
            sum = {1'b0, i_start} + (CL_S + 1)'(k);
            if (sum >= NsrcW) begin
                sum = sum - NsrcW;
            end
            cand = sum[CL_S-1:0];
            if (!found && i_req[cand]) begin
                found = 1'b1;
                o_idx = cand;
            end
        end
    end

endmodule

// File: rtl/sfifo_rr_arbiter.sv
// Merges NSRC rdy/ack producers into one registered rdy/ack slot, round-robin with an
// optional burst hold, tagging each word with the index of the producer it came from.
module sfifo_rr_arbiter
    import sfifo_rr_arbiter_pkg::*;
#(
    parameter int unsigned NSRC  = 4,
    parameter int unsigned BW    = 8,
    parameter int unsigned BURST = 1,
    localparam int unsigned CL_S = $clog2(NSRC),
    localparam int unsigned CL_B = cnt_width(BURST)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NSRC-1:0]    src_rdy,
    output logic [NSRC-1:0]    src_ack,
    input  logic [NSRC*BW-1:0] i_data,
    output logic               dst_rdy,
    input  logic               dst_ack,
    output logic [BW-1:0]      o_data,
    output logic [CL_S-1:0]    o_id
);

    localparam logic [CL_S-1:0] LastIdx   = CL_S'(NSRC - 1);
    localparam logic [CL_B-1:0] BurstLast = CL_B'(BURST - 1);
    localparam logic [CL_B-1:0] CntStart  = (BURST == 1) ? '0 : CL_B'(1);

    logic            valid_q, valid_d;
    logic [BW-1:0]   data_q, data_d;
    logic [CL_S-1:0] id_q, id_d;
    logic [CL_S-1:0] ptr_q, ptr_d;
    logic [CL_S-1:0] owner_q, owner_d;
    logic [CL_B-1:0] cnt_q, cnt_d;

    logic            can_take;
    logic            pick_any;
    logic [CL_S-1:0] pick_idx;
    logic            hold;
    logic            xfer;
    logic [CL_S-1:0] grant;
    logic [BW-1:0]   data_sel;

    sfifo_rr_arbiter_rr_pick #(
        .NSRC (NSRC)
    ) u_pick (
        .i_req   (src_rdy),
        .i_start (ptr_q),
        .o_any   (pick_any),
        .o_idx   (pick_idx)
    );

    assign can_take = !valid_q || dst_ack;
    assign hold     = (cnt_q != '0) && src_rdy[owner_q];
    assign grant    = hold ? owner_q : pick_idx;
    assign xfer     = can_take && pick_any;

    always_comb begin
        src_ack  = '0;
        data_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant == CL_S'(i)) begin
                src_ack[i] = xfer;
                data_sel   = i_data[i*BW +: BW];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            valid_d = 1'b1;
            data_d  = data_sel;
            id_d    = grant;
            ptr_d   = (grant == LastIdx) ? '0 : grant + 1'b1;
            if ((cnt_q != '0) && (grant == owner_q)) begin
                cnt_d = (cnt_q == BurstLast) ? '0 : cnt_q + 1'b1;
            end else begin
                owner_d = grant;
                cnt_d   = CntStart;
            end
        end else begin
            if (dst_ack) begin
                valid_d = 1'b0;
            end
            // Owner went idle mid-burst: drop the burst rather than wait for it.
            if (can_take && (cnt_q != '0) && !src_rdy[owner_q]) begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dst_rdy = valid_q;
    assign o_data  = data_q;
    assign o_id    = id_q;

endmodule

// File: tb/tb_sfifo_rr_arbiter.sv
// Directed bench: a pure round-robin instance and a BURST=3 instance, checked against
// hand-computed grant, index and payload sequences.
module tb_sfifo_rr_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [3:0]  rdy1, ack1, rdy3, ack3;
    logic        dack1, dack3;
    logic        drdy1, drdy3;
    logic [7:0]  odata1, odata3;
    logic [1:0]  oid1, oid3;
    logic [31:0] src_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    assign src_data = {8'h44, 8'h33, 8'h22, 8'h11};

    sfifo_rr_arbiter #(.NSRC(4), .BW(8), .BURST(1)) u_dut_b1 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .src_rdy (rdy1),
        .src_ack (ack1),
        .i_data  (src_data),
        .dst_rdy (drdy1),
        .dst_ack (dack1),
        .o_data  (odata1),
        .o_id    (oid1)
    );

    sfifo_rr_arbiter #(.NSRC(4), .BW(8), .BURST(3)) u_dut_b3 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .src_rdy (rdy3),
        .src_ack (ack3),
        .i_data  (src_data),
        .dst_rdy (drdy3),
        .dst_ack (dack3),
        .o_data  (odata3),
        .o_id    (oid3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs already driven: check the combinational grant, clock once, check the slot.
    task automatic cycle(input string tag, input bit b3, input logic [3:0] exp_ack,
                         input bit exp_rdy, input int exp_id);
        logic [7:0] exp_data;
        exp_data = exp_rdy ? 8'((exp_id + 1) * 8'h11) : 8'h00;
        #1;
        check({tag, ".src_ack"}, b3 ? ack3 : ack1, exp_ack);
        @(posedge i_clk);
        #1;
        check({tag, ".dst_rdy"}, b3 ? drdy3 : drdy1, exp_rdy);
        check({tag, ".o_id"}, b3 ? oid3 : oid1, exp_id);
        check({tag, ".o_data"}, b3 ? odata3 : odata1, exp_data);
    endtask

    initial begin
        int rr_ids[6]  = '{0, 1, 2, 3, 0, 1};
        int alt_ids[4] = '{3, 1, 3, 1};
        int b3_ids[7]  = '{0, 0, 0, 1, 1, 1, 2};

        i_rst = 1'b1;
        rdy1  = 4'b0000;
        rdy3  = 4'b0000;
        dack1 = 1'b0;
        dack3 = 1'b0;
        @(posedge i_clk);
        #1;
        check("rst.dst_rdy", drdy1, 1'b0);
        check("rst.o_data", odata1, 8'h00);
        check("rst.o_id", oid1, 2'd0);
        check("rst.src_ack", ack1, 4'b0000);
        check("rst.b3_dst_rdy", drdy3, 1'b0);
        i_rst = 1'b0;

        // All ready, consumer always accepting: strict rotation, one word per cycle.
        rdy1  = 4'b1111;
        dack1 = 1'b1;
        foreach (rr_ids[k]) begin
            cycle("rr", 1'b0, 4'(1 << rr_ids[k]), 1'b1, rr_ids[k]);
        end

        // Pointer now at 2; only producers 1 and 3 request.
        rdy1 = 4'b1010;
        foreach (alt_ids[k]) begin
            cycle("alt", 1'b0, 4'(1 << alt_ids[k]), 1'b1, alt_ids[k]);
        end

        // Full slot, consumer stalls: no grants, slot word held.
        rdy1  = 4'b1111;
        dack1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle("stall", 1'b0, 4'b0000, 1'b1, 1);
        end
        dack1 = 1'b1;
        cycle("refill", 1'b0, 4'b0100, 1'b1, 2);

        // Bring ptr to 2 with the slot full, then reset mid-operation.
        rdy1 = 4'b0010;
        cycle("preset", 1'b0, 4'b0010, 1'b1, 1);
        rdy1  = 4'b0000;
        dack1 = 1'b0;
        i_rst = 1'b1;
        cycle("midrst", 1'b0, 4'b0000, 1'b0, 0);
        i_rst = 1'b0;
        rdy1  = 4'b1111;
        dack1 = 1'b1;
        cycle("postrst", 1'b0, 4'b0001, 1'b1, 0);

        // Burst instance: three words per owner.
        rdy3  = 4'b1111;
        dack3 = 1'b1;
        foreach (b3_ids[k]) begin
            cycle("burst", 1'b1, 4'(1 << b3_ids[k]), 1'b1, b3_ids[k]);
        end
        // Producer 2 drops after one word: burst abandoned, 3 wins and starts its own.
        rdy3 = 4'b1011;
        cycle("abandon", 1'b1, 4'b1000, 1'b1, 3);
        cycle("newburst", 1'b1, 4'b1000, 1'b1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sfifo_rr_arbiter.md
# sfifo_rr_arbiter

Round-robin arbiter that merges `NSRC` independent rdy/ack producer streams into one rdy/ack stream feeding a shared `SFifo`. It sits directly in front of the FIFO `src` port and tags every word with its producer index. It sustains one transfer per cycle through a single registered output slot. An optional burst mode lets the current winner keep the grant for up to `BURST` consecutive words.

## Interface
Parameters:
- `NSRC`, 4: number of producers, ≥2.
- `BW`, 8: data width.
- `BURST`, 1: maximum consecutive grants to one producer, ≥1.
- `CL_S` (local): `$clog2(NSRC)`.
- `CL_B` (local): `$clog2(BURST+1)`.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `src_rdy`  in  NSRC  per-producer request.
- `src_ack`  out  NSRC  per-producer accept, one-hot or zero.
- `i_data`  in  [NSRC] x BW  per-producer payload.
- `dst_rdy`  out  1  output slot valid.
- `dst_ack`  in  1  consumer accept.
- `o_data`  out  BW  slot payload.
- `o_id`  out  CL_S  producer index of the slot payload.

## Operation
- Handshake rules:
  - A transfer occurs on a cycle with `rdy && ack`.
  - A producer holds `src_rdy` and `i_data` stable until acked.
  - `src_ack` is combinational from `src_rdy`, state and `dst_ack`.
- State registers: `valid_r`, `data_r`, `id_r`, `ptr_r` (next RR start, CL_S bits), `owner_r` (CL_S bits), `cnt_r` (CL_B bits).
- Accept condition: `can_take = !valid_r || dst_ack`.
- Winner selection, when `can_take` and `|src_rdy`:
  - If `cnt_r != 0 && src_rdy[owner_r]`: `g = owner_r` (burst hold).
  - Otherwise `g` is the first set bit of `src_rdy` scanning `ptr_r, ptr_r+1, …` modulo NSRC.
  - `src_ack = 1 << g`. If no producer is ready, `src_ack = 0`.
- On an acked transfer from `g`:
  - Slot: `data_r <= i_data[g]`, `id_r <= g`, `valid_r <= 1`.
  - Pointer: `ptr_r <= (g == NSRC-1) ? 0 : g+1`, on every transfer.
  - Burst continuation (`cnt_r != 0 && g == owner_r`): `cnt_r <= (cnt_r == BURST-1) ? 0 : cnt_r+1`.
  - New burst (any other case): `owner_r <= g`, `cnt_r <= (BURST == 1) ? 0 : 1`.
- `dst_ack` without a source transfer: `valid_r <= 0`.
- Burst abandon: `can_take && cnt_r != 0 && !src_rdy[owner_r]` with no transfer sets `cnt_r <= 0`. While stalled (`!can_take`), `cnt_r` and `owner_r` hold.

## Timing
- Reset outputs, on the first edge with `i_rst = 1`: `dst_rdy = 0`, `o_data = 0`, `o_id = 0`, `src_ack = 0`.
- Reset state: `ptr_r = 0`, `owner_r = 0`, `cnt_r = 0`.
- Reset mid-operation discards the slot word. An acked source word in the reset cycle is lost; the producer owns that case.
- Latency: `src_ack` in cycle t gives `dst_rdy = 1` with that word in cycle t+1.
- Throughput: one word per cycle when the consumer acks every cycle (simultaneous drain and refill keeps `valid_r = 1`).
- Full slot with `dst_ack = 0`: all `src_ack = 0`, all state holds.
- Wrap-around: after a grant to index NSRC-1, `ptr_r = 0`.
- With `BURST = 1`, `cnt_r` stays 0 and the behaviour is pure round-robin.
- Fairness bound: a continuously ready producer waits at most `(NSRC-1)*BURST` transfers.

## Structure
- Shared package `ArbPkg`: producer-index typedef `id_t` (CL_S bits) and the burst-counter width helper.
- Sub-module `RrPick`: combinational rotate-priority encoder.
  - Inputs: `i_req[NSRC]`, `i_start[CL_S]`.
  - Outputs: `o_any`, `o_idx[CL_S]`.
  - Reused by other arbiters in the codebase.
- Top-level contents: burst override, slot register, pointer/owner/counter updates.

## Test plan
- Reset, then `src_rdy = 4'b1111` and `dst_ack = 1` every cycle (NSRC=4, BURST=1) → `o_id` sequence 0,1,2,3,0,1 starting one cycle after the first ack; `dst_rdy` stays 1.
- `src_rdy = 4'b1010` and `dst_ack = 1` held constant → `o_id` alternates 1,3,1,3. `src_ack[0]` and `src_ack[2]` are never asserted.
- Slot filled, then `dst_ack = 0` for 5 cycles with `src_rdy = 4'b1111` → `src_ack = 0` all 5 cycles; `o_data` and `o_id` hold. The first `dst_ack` cycle refills from `ptr_r`.
- BURST=3, all ready, `dst_ack = 1` → `o_id` 0,0,0,1,1,1,2,2,2.
- BURST=3, producer 2 drops `src_rdy` after its first word → the burst is abandoned and the next grant is 3.
- Assert `i_rst` for 1 cycle while `dst_rdy = 1` and `ptr_r = 2` → next cycle `dst_rdy = 0`, `o_id = 0`. The next grant with all producers ready is index 0.
